// File: rtl/fwrisc_mul_sched_pkg.sv
// rtl/fwrisc_mul_sched_pkg.sv - shared state type, widths and op codes for the multiplier scheduler
package fwrisc_mul_sched_pkg;

  localparam int DATA_W = 32;
  localparam int OP_W   = 4;

  localparam logic [OP_W-1:0] OP_MUL   = 4'd0;
  localparam logic [OP_W-1:0] OP_MULH  = 4'd1;
  localparam logic [OP_W-1:0] OP_MULS  = 4'd2;
  localparam logic [OP_W-1:0] OP_MULSH = 4'd3;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

endpackage

// File: rtl/fwrisc_rr_arb.sv
// rtl/fwrisc_rr_arb.sv - combinational round-robin pick starting at rr_ptr
module fwrisc_rr_arb #(
  parameter int N = 2
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] rr_ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx
);

  localparam int IW = $clog2(N);

  // Scan from the farthest slot back towards rr_ptr so the closest request wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin : scan
      int j;
      j = int'(rr_ptr) + k;
      if (j >= N) j = j - N;
      if (req[IW'(j)]) begin
        grant     = N'(1) << j;
        grant_idx = IW'(j);
      end
    end
  end

endmodule

// File: rtl/fwrisc_mul_sched.sv
// rtl/fwrisc_mul_sched.sv - shares one multiplier between NUM_REQ requesters with a watchdog.
// FWRISC_MUL_SCHED_CACHE_EN adds a one-entry result cache that bypasses the multiplier.
module fwrisc_mul_sched
  import fwrisc_mul_sched_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*32-1:0]   req_a,
  input  logic [NUM_REQ*32-1:0]   req_b,
  input  logic [NUM_REQ*4-1:0]    req_op,
  output logic [NUM_REQ-1:0]      rsp_valid,
  input  logic [NUM_REQ-1:0]      rsp_ready,
  output logic [DATA_W-1:0]       rsp_data,
  output logic                    rsp_err,
  output logic [DATA_W-1:0]       mul_in_a,
  output logic [DATA_W-1:0]       mul_in_b,
  output logic [OP_W-1:0]         mul_op,
  output logic                    mul_in_valid,
  input  logic [DATA_W-1:0]       mul_out,
  input  logic                    mul_out_valid,
  output logic                    busy
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT_CYCLES);

  state_e              state, state_n;
  logic [IW-1:0]       rr_ptr, g_q, grant_idx;
  logic [NUM_REQ-1:0]  grant, g_onehot;
  logic [DATA_W-1:0]   a_q, b_q, sel_a, sel_b, rsp_data_q, cache_res;
  logic [OP_W-1:0]     op_q, sel_op;
  logic [CW-1:0]       cnt;
  logic                rsp_err_q, any_req, timeout, rsp_hs, cache_hit;

  fwrisc_rr_arb #(.N(NUM_REQ)) u_arb (
    .req       (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    sel_a  = '0;
    sel_b  = '0;
    sel_op = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[IW'(i)]) begin
        sel_a  = req_a[DATA_W*i +: DATA_W];
        sel_b  = req_b[DATA_W*i +: DATA_W];
        sel_op = req_op[OP_W*i +: OP_W];
      end
    end
  end

  assign any_req  = |grant;
  assign timeout  = (cnt == CW'(TIMEOUT_CYCLES - 1));
  assign g_onehot = NUM_REQ'(1) << g_q;
  assign rsp_hs   = (state == RESP) && |(rsp_ready & g_onehot);

`ifdef FWRISC_MUL_SCHED_CACHE_EN
  logic              cache_valid;
  logic [DATA_W-1:0] cache_a, cache_b;
  logic [OP_W-1:0]   cache_op;

  assign cache_hit = cache_valid && (cache_a == sel_a) && (cache_b == sel_b) && (cache_op == sel_op);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cache_valid <= 1'b0;
      cache_a     <= '0;
      cache_b     <= '0;
      cache_op    <= '0;
      cache_res   <= '0;
    end else if (state == WAIT) begin
      if (mul_out_valid) begin
        cache_valid <= 1'b1;
        cache_a     <= a_q;
        cache_b     <= b_q;
        cache_op    <= op_q;
        cache_res   <= mul_out;
      end else if (timeout) begin
        cache_valid <= 1'b0;
      end
    end
  end
`else
  assign cache_hit = 1'b0;
  assign cache_res = '0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n      = state;
    req_ready    = '0;
    rsp_valid    = '0;
    mul_in_valid = 1'b0;
    busy         = (state != IDLE);
    case (state)
      IDLE: begin
        // Gate with reset so nothing is granted while reset is held.
        if (reset) req_ready = grant;
        if (any_req) state_n = cache_hit ? RESP : ISSUE;
      end
      ISSUE: begin
        mul_in_valid = 1'b1;
        state_n      = WAIT;
      end
      WAIT: begin
        if (mul_out_valid || timeout) state_n = RESP;
      end
      RESP: begin
        rsp_valid = g_onehot;
        if (rsp_hs) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr     <= '0;
      g_q        <= '0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      cnt        <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            a_q  <= sel_a;
            b_q  <= sel_b;
            op_q <= sel_op;
            g_q  <= grant_idx;
            if (cache_hit) begin
              rsp_data_q <= cache_res;
              rsp_err_q  <= 1'b0;
            end
          end
        end
        ISSUE: cnt <= '0;
        WAIT: begin
          cnt <= cnt + CW'(1);
          // A result arriving on the last watchdog cycle still wins.
          if (mul_out_valid) begin
            rsp_data_q <= mul_out;
            rsp_err_q  <= 1'b0;
          end else if (timeout) begin
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_hs) rr_ptr <= (g_q == IW'(NUM_REQ - 1)) ? '0 : g_q + IW'(1);
        end
        default: ;
      endcase
    end
  end

  assign mul_in_a = a_q;
  assign mul_in_b = b_q;
  assign mul_op   = op_q;
  assign rsp_data = rsp_data_q;
  assign rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_fwrisc_mul_sched.sv
// tb/tb_fwrisc_mul_sched.sv - scoreboard bench with a multiplier stub and round-robin reference model
module tb_fwrisc_mul_sched;
  import fwrisc_mul_sched_pkg::*;

  localparam int N  = 2;
  localparam int IW = $clog2(N);
  localparam int TO = 16;
`ifdef FWRISC_MUL_SCHED_CACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          t_grant;
    int          lat;
  } exp_t;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic [N-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
  logic [32*N-1:0] req_a, req_b;
  logic [4*N-1:0]  req_op;
  logic [31:0]     rsp_data, mul_in_a, mul_in_b, mul_out;
  logic            rsp_err, mul_in_valid, mul_out_valid, busy;
  logic [3:0]      mul_op;

  int errors = 0, checks = 0, cyc = 0;
  int stub_lat = 1, cur_lat = 1, stub_due = -1, ready_mode = 0, miv_count = 0;
  logic [31:0] stub_res;

  exp_t        exp_q[N][$];
  bit          seen[N];
  int          model_ptr, exp_issue;
  bit          model_idle;
  logic [31:0] ei_a, ei_b, last_data;
  logic [3:0]  ei_op;
  logic        last_err;
  bit          c_valid;
  logic [31:0] c_a, c_b, c_res;
  logic [3:0]  c_op;

  fwrisc_mul_sched #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mul_in_a(mul_in_a), .mul_in_b(mul_in_b), .mul_op(mul_op),
    .mul_in_valid(mul_in_valid), .mul_out(mul_out), .mul_out_valid(mul_out_valid),
    .busy(busy)
  );

  always #5 clock = ~clock;

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic logic [31:0] mul_fn(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    logic [63:0] u, s;
    u = {32'b0, a} * {32'b0, b};
    s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    case (op)
      OP_MUL:   return u[31:0];
      OP_MULH:  return u[63:32];
      OP_MULS:  return s[31:0];
      OP_MULSH: return s[63:32];
      default:  return a ^ b;
    endcase
  endfunction

  function automatic logic [N-1:0] rr_pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[IW'((p + k) % N)]) return N'(1) << ((p + k) % N);
    return '0;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      exp_q[IW'(i)].delete();
      seen[IW'(i)] = 1'b0;
    end
    model_ptr  = 0;
    model_idle = 1'b1;
    exp_issue  = -1;
    c_valid    = 1'b0;
  endfunction

  // Expected response for a request accepted in the current cycle.
  function automatic void predict(input int r, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    exp_t e;
    e.t_grant = cyc;
    if (CACHE_EN && c_valid && c_a == a && c_b == b && c_op == op) begin
      e.data = c_res; e.err = 1'b0; e.lat = 1;
      exp_issue = -1;
    end else begin
      exp_issue = cyc + 1;
      ei_a = a; ei_b = b; ei_op = op;
      cur_lat = stub_lat;
      if (stub_lat != 0) begin
        e.data = mul_fn(a, b, op); e.err = 1'b0; e.lat = stub_lat + 2;
        c_valid = 1'b1; c_a = a; c_b = b; c_op = op; c_res = e.data;
      end else begin
        e.data = '0; e.err = 1'b1; e.lat = TO + 2;
        c_valid = 1'b0;
      end
    end
    exp_q[IW'(r)].push_back(e);
  endfunction

  task automatic send(input int r, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    bit got;
    @(posedge clock); #1;
    req_a[32*r +: 32] = a;
    req_b[32*r +: 32] = b;
    req_op[4*r +: 4]  = op;
    req_valid[IW'(r)] = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 300 && !got; n++) begin
      @(negedge clock);
      if (req_ready[IW'(r)]) got = 1'b1;
    end
    if (got) predict(r, a, b, op);
    else chk("accept_timeout", 64'(got), 64'd1);
    @(posedge clock); #1;
    req_valid[IW'(r)] = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 400 && (exp_q[0].size() + exp_q[1].size()) != 0; n++) @(negedge clock);
    chk("drain", 64'(exp_q[0].size() + exp_q[1].size()), 64'd0);
    @(negedge clock);
  endtask

  task automatic do_reset();
    @(posedge clock); #2;
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctrl"}, 64'({req_ready, rsp_valid, rsp_err, mul_in_valid, busy}), 64'd0);
    chk({tag, "_rsp_data"}, 64'(rsp_data), 64'd0);
    chk({tag, "_mul_a"}, 64'(mul_in_a), 64'd0);
    chk({tag, "_mul_b"}, 64'(mul_in_b), 64'd0);
    chk({tag, "_mul_op"}, 64'(mul_op), 64'd0);
  endtask

  // Multiplier stub: result after cur_lat cycles, cur_lat == 0 means it never answers.
  initial forever begin
    @(negedge clock);
    if (mul_in_valid) begin
      stub_due = (cur_lat == 0) ? -1 : cyc + cur_lat;
      stub_res = mul_fn(mul_in_a, mul_in_b, mul_op);
    end
  end

  initial begin
    mul_out_valid = 1'b0;
    mul_out       = '0;
    rsp_ready     = '1;
    forever begin
      @(posedge clock); #1;
      mul_out_valid = (cyc == stub_due);
      mul_out       = (cyc == stub_due) ? stub_res : $urandom;
      case (ready_mode)
        1:       rsp_ready = N'($urandom);
        2:       rsp_ready = 2'b10;
        default: rsp_ready = '1;
      endcase
    end
  end

  initial begin : monitor
    exp_t e;
    logic [N-1:0] er;
    forever begin
      @(negedge clock);
      if (reset) begin
        er = model_idle ? rr_pick(req_valid, model_ptr) : '0;
        chk("req_ready", 64'(req_ready), 64'(er));
        chk("busy", 64'(busy), 64'(!model_idle));
        chk("mul_in_valid", 64'(mul_in_valid), 64'(cyc == exp_issue));
        if (mul_in_valid) begin
          miv_count++;
          chk("mul_in_a", 64'(mul_in_a), 64'(ei_a));
          chk("mul_in_b", 64'(mul_in_b), 64'(ei_b));
          chk("mul_op", 64'(mul_op), 64'(ei_op));
        end
        if (req_ready != '0) model_idle = 1'b0;
        for (int i = 0; i < N; i++) begin
          if (rsp_valid[IW'(i)]) begin
            if (exp_q[IW'(i)].size() == 0) begin
              chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
            end else begin
              e = exp_q[IW'(i)][0];
              chk("rsp_data", 64'(rsp_data), 64'(e.data));
              chk("rsp_err", 64'(rsp_err), 64'(e.err));
              if (!seen[IW'(i)]) begin
                chk("rsp_latency", 64'(cyc - e.t_grant), 64'(e.lat));
                seen[IW'(i)] = 1'b1;
              end
              if (rsp_ready[IW'(i)]) begin
                void'(exp_q[IW'(i)].pop_front());
                seen[IW'(i)] = 1'b0;
                model_ptr  = (i + 1) % N;
                model_idle = 1'b1;
                last_data  = rsp_data;
                last_err   = rsp_err;
              end
            end
          end
        end
      end
    end
  end

  initial begin
    logic [1:0]  m;
    logic [31:0] a0, b0, a1, b1;
    logic [3:0]  o0, o1;
    int          m0;
    req_valid = '0; req_a = '0; req_b = '0; req_op = '0;
    model_reset();
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk_zero("reset");
    @(posedge clock); #1 reset = 1'b1;

    stub_lat = 1;
    send(0, 32'd7, 32'd6, OP_MUL);
    drain();
    chk("t1_data", 64'(last_data), 64'd42);
    chk("t1_err", 64'(last_err), 64'd0);

    do_reset();
    repeat (2) begin
      fork
        send(0, $urandom, $urandom, OP_MUL);
        send(1, $urandom, $urandom, OP_MULSH);
      join
    end
    drain();

    ready_mode = 2;
    send(0, 32'd9, 32'd11, OP_MUL);
    fork
      send(1, 32'h1234_5678, 32'h10, OP_MULH);
      begin : stall_chk
        int n;
        n = 0;
        while (!rsp_valid[0] && n < 50) begin @(negedge clock); n++; end
        chk("stall_seen", 64'(rsp_valid[0]), 64'd1);
        repeat (5) begin
          @(negedge clock);
          chk("stall_busy", 64'(busy), 64'd1);
          chk("stall_req_ready", 64'(req_ready), 64'd0);
          chk("stall_rsp_valid", 64'(rsp_valid), 64'd1);
          chk("stall_data", 64'(rsp_data), 64'd99);
        end
        ready_mode = 0;
      end
    join
    drain();

    stub_lat = 0;
    send(1, 32'hdead, 32'hbeef, OP_MUL);
    drain();
    chk("t4_err", 64'(last_err), 64'd1);
    chk("t4_data", 64'(last_data), 64'd0);
    stub_lat = 1;
    send(1, 32'd12, 32'd12, OP_MUL);
    drain();
    chk("t4_next", 64'(last_data), 64'd144);

    stub_lat = TO;
    send(0, 32'hffff_ffff, 32'd2, OP_MULH);
    drain();
    chk("late_valid_err", 64'(last_err), 64'd0);

    stub_lat = 1;
    send(0, 32'd3, 32'd5, OP_MUL);
    drain();
    m0 = miv_count;
    send(0, 32'd3, 32'd5, OP_MUL);
    drain();
    chk("t5_data", 64'(last_data), 64'd15);
    chk("t5_issue_count", 64'(miv_count - m0), CACHE_EN ? 64'd0 : 64'd1);

    ready_mode = 1;
    for (int it = 0; it < 40; it++) begin
      m = 2'($urandom_range(1, 3));
      stub_lat = $urandom_range(1, TO);
      a0 = $urandom; b0 = $urandom; o0 = 4'($urandom_range(0, 3));
      a1 = $urandom; b1 = $urandom; o1 = 4'($urandom_range(0, 3));
      fork
        if (m[0]) send(0, a0, b0, o0);
        if (m[1]) send(1, a1, b1, o1);
      join
    end
    ready_mode = 0;
    drain();

    stub_lat = 12;
    send(0, 32'h11, 32'h22, OP_MUL);
    @(posedge clock);
    @(posedge clock); #2;
    reset = 1'b0;
    #1 chk_zero("t6");
    model_reset();
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    repeat (20) @(negedge clock);
    stub_lat = 1;
    send(1, 32'd6, 32'd7, OP_MUL);
    drain();
    chk("t6_after", 64'(last_data), 64'd42);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
